// File: rtl/wb_host_master_if.sv
// Command/response handshake and Wishbone bus bundle for wb_host_master.
// The master modport is the initiator side; slave is the host/bench side.
interface wb_host_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_timeout;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr,
    input  cmd_dat, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_timeout,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr,
    output cmd_dat, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_timeout,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator with slave timeout.
// One bus cycle per command; read data or write status returned per response.
module wb_host_master #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADDEAD
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  wb_host_master_if.master bus,
  output logic        busy,
  output logic [15:0] txn_count,
  output logic [7:0]  timeout_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;

  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        rvld_q, rvld_d;
  logic [31:0] rdat_q, rdat_d;
  logic        rto_q, rto_d;
  logic [15:0] txn_q, txn_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [7:0]  wait_q, wait_d;

  logic accept;
  logic done;
  logic expire;

  assign bus.cmd_ready = (state_q == IDLE) & ~wb_rst_i;
  assign accept = bus.cmd_valid & bus.cmd_ready;
  assign expire = ~bus.wbm_ack_i & (wait_q == TO_LAST);
  assign done   = bus.wbm_ack_i | expire;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)        state_d = BUS;
      BUS:     if (done)          state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Ack is checked before expiry so an ack on the last wait edge completes normally.
  always_comb begin
    cyc_d  = cyc_q;
    we_d   = we_q;
    sel_d  = sel_q;
    adr_d  = adr_q;
    wdat_d = wdat_q;
    rvld_d = rvld_q;
    rdat_d = rdat_q;
    rto_d  = rto_q;
    txn_d  = txn_q;
    tcnt_d = tcnt_q;
    wait_d = wait_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cyc_d  = 1'b1;
          we_d   = bus.cmd_we;
          sel_d  = bus.cmd_sel;
          adr_d  = bus.cmd_adr;
          wdat_d = bus.cmd_dat;
          wait_d = 8'd0;
        end
      end
      BUS: begin
        if (bus.wbm_ack_i) begin
          cyc_d  = 1'b0;
          rvld_d = 1'b1;
          rdat_d = bus.wbm_dat_i;
          rto_d  = 1'b0;
          txn_d  = txn_q + 16'd1;
        end else if (expire) begin
          cyc_d  = 1'b0;
          rvld_d = 1'b1;
          rdat_d = TIMEOUT_DATA;
          rto_d  = 1'b1;
          txn_d  = txn_q + 16'd1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) rvld_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= 4'd0;
      adr_q  <= 32'd0;
      wdat_q <= 32'd0;
      rvld_q <= 1'b0;
      rdat_q <= 32'd0;
      rto_q  <= 1'b0;
      txn_q  <= 16'd0;
      tcnt_q <= 8'd0;
      wait_q <= 8'd0;
    end else begin
      cyc_q  <= cyc_d;
      we_q   <= we_d;
      sel_q  <= sel_d;
      adr_q  <= adr_d;
      wdat_q <= wdat_d;
      rvld_q <= rvld_d;
      rdat_q <= rdat_d;
      rto_q  <= rto_d;
      txn_q  <= txn_d;
      tcnt_q <= tcnt_d;
      wait_q <= wait_d;
    end
  end

  assign bus.wbm_cyc_o   = cyc_q;
  assign bus.wbm_stb_o   = cyc_q;
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_sel_o   = sel_q;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = wdat_q;
  assign bus.rsp_valid   = rvld_q;
  assign bus.rsp_dat     = rdat_q;
  assign bus.rsp_timeout = rto_q;

  assign busy          = (state_q != IDLE);
  assign txn_count     = txn_q;
  assign timeout_count = tcnt_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Randomized bench for wb_host_master against a register-slave BFM.
// Expected responses come from a transaction-level memory/counter model.
module tb_wb_host_master;

  localparam int TO    = 15;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] txn_count;
  logic [7:0]  timeout_count;

  wb_host_master_if bus();

  wb_host_master #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_DATA(32'hDEADDEAD)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus),
    .busy(busy),
    .txn_count(txn_count),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave BFM: acks after ack_delay strobe edges; optional trailing stray ack.
  logic        s_ack = 1'b0;
  logic        ack_force = 1'b0;
  logic [31:0] s_dat = 32'd0;
  int          scnt = 0;
  int          ack_delay = NEVER;
  bit          stray_en = 1'b0;
  logic [31:0] smem [4];

  assign bus.wbm_ack_i = s_ack | ack_force;
  assign bus.wbm_dat_i = s_dat;

  always @(posedge clk) begin
    if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
      scnt <= scnt + 1;
      if (scnt == ack_delay) begin
        s_ack <= 1'b1;
        if (bus.wbm_adr_o[31:4] != 28'h3000000) begin
          s_dat <= 32'd0;
        end else if (bus.wbm_we_o) begin
          if (bus.wbm_adr_o[3:2] == 2'd1) begin
            s_dat <= 32'd0;
          end else begin
            for (int b = 0; b < 4; b++)
              if (bus.wbm_sel_o[b])
                smem[bus.wbm_adr_o[3:2]][8*b +: 8] <= bus.wbm_dat_o[8*b +: 8];
            s_dat <= 32'd1;
          end
        end else begin
          s_dat <= smem[bus.wbm_adr_o[3:2]];
        end
      end else begin
        s_ack <= s_ack & stray_en;
      end
    end else begin
      scnt  <= 0;
      s_ack <= 1'b0;
    end
  end

  int n_rsp = 0;
  always @(posedge clk)
    if (bus.rsp_valid && bus.rsp_ready) n_rsp <= n_rsp + 1;

  // Reference model
  logic [31:0] mmem [4];
  int          m_txn = 0;
  int          m_to  = 0;
  int          m_rsp = 0;

  function automatic logic [31:0] ref_access(input bit we,
                                             input logic [31:0] adr,
                                             input logic [31:0] dat,
                                             input logic [3:0] sel);
    logic [31:0] m;
    int i;
    if (adr[31:4] != 28'h3000000) return 32'd0;
    i = int'(adr[3:2]);
    if (!we) return mmem[i];
    if (i == 1) return 32'd0;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    mmem[i] = (mmem[i] & ~m) | (dat & m);
    return 32'd1;
  endfunction

  task automatic do_txn(input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input int dly, input bit stray, input int hold);
    logic [31:0] exp_dat;
    logic [31:0] held;
    bit exp_to;
    int k, stb_n, bad, bp_bad;
    ack_delay = dly;
    stray_en  = stray;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    bus.cmd_sel   = sel;
    chk("cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = ~we;
    bus.cmd_adr   = $urandom;
    bus.cmd_dat   = $urandom;
    bus.cmd_sel   = ~sel;
    exp_to  = (dly > TO - 2);
    exp_dat = exp_to ? 32'hDEADDEAD : ref_access(we, adr, dat, sel);
    m_txn++;
    m_rsp++;
    if (exp_to && m_to != 255) m_to++;
    k = 0; stb_n = 0; bad = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (bus.rsp_valid) break;
      if (bus.wbm_stb_o) begin
        stb_n++;
        if (!bus.wbm_cyc_o || bus.wbm_we_o !== we || bus.wbm_adr_o !== adr ||
            bus.wbm_dat_o !== dat || bus.wbm_sel_o !== sel)
          bad++;
      end
    end
    chk("rsp_lat", k, exp_to ? TO + 1 : dly + 3);
    chk("stb_cycles", stb_n, exp_to ? TO : dly + 2);
    chk("bus_hold", bad, 0);
    chk("stb_drop", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
    chk("rsp_dat", bus.rsp_dat, exp_dat);
    chk("rsp_timeout", bus.rsp_timeout, exp_to);
    chk("busy_resp", busy, 1);
    held = bus.rsp_dat;
    bp_bad = 0;
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_dat !== held || bus.cmd_ready ||
          bus.wbm_cyc_o)
        bp_bad++;
    end
    bus.cmd_valid = 1'b0;
    if (hold > 0) chk("backpressure", bp_bad, 0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_cleared", bus.rsp_valid, 0);
    chk("busy_idle", busy, 0);
    chk("txn_count", txn_count, m_txn[15:0]);
    chk("timeout_count", timeout_count, m_to[7:0]);
  endtask

  function automatic logic [31:0] pick_adr();
    int p;
    p = int'($urandom_range(0, 4));
    if (p == 4) return 32'h4000_0000 | ($urandom & 32'hFFC);
    return 32'h3000_0000 + 32'(p * 4);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    smem[0] = 32'h0000_0000; mmem[0] = 32'h0000_0000;
    smem[1] = 32'h4669_626F; mmem[1] = 32'h4669_626F;
    smem[2] = 32'hA5A5_0F0F; mmem[2] = 32'hA5A5_0F0F;
    smem[3] = 32'h1234_5678; mmem[3] = 32'h1234_5678;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 32'd0;
    bus.cmd_dat   = 32'd0;
    bus.cmd_sel   = 4'd0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_timeout, bus.rsp_dat}, 0);
    chk("rst_bus", {bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o, 32'd0}, 0);
    chk("rst_wdat", bus.wbm_dat_o, 0);
    chk("rst_counts", {txn_count, timeout_count, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("cmd_ready_after_rst", bus.cmd_ready, 1);

    do_txn(0, 32'h3000_0004, 32'h0, 4'hF, 0, 1, 0);
    do_txn(1, 32'h3000_000C, 32'h0, 4'hF, 1, 1, 0);
    do_txn(0, 32'h3000_000C, 32'h0, 4'hF, 0, 0, 0);
    do_txn(0, 32'h3000_0008, 32'h0, 4'hF, NEVER, 0, 0);
    do_txn(0, 32'h3000_0008, 32'h0, 4'hF, 2, 0, 0);
    do_txn(0, 32'h3000_0004, 32'h0, 4'hF, 0, 1, 5);
    do_txn(1, 32'h3000_0008, 32'hCAFE_BEEF, 4'h5, 13, 0, 0);
    do_txn(0, 32'h3000_0008, 32'h0, 4'hF, 13, 1, 2);

    for (int i = 0; i < 40; i++) begin
      int d;
      d = (($urandom % 6) == 0) ? NEVER : int'($urandom_range(0, 13));
      do_txn(1'($urandom), pick_adr(), $urandom, 4'($urandom), d,
             1'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset while the strobe is up and no ack is coming.
    ack_delay = NEVER;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_adr   = 32'h3000_0000;
    bus.cmd_dat   = 32'h1111_2222;
    bus.cmd_sel   = 4'hF;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_bus_stb", bus.wbm_stb_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
    chk("async_rsp_busy", {bus.rsp_valid, busy}, 0);
    chk("async_cmd_ready", bus.cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    m_txn = 0;
    m_to  = 0;
    @(negedge clk);
    chk("post_rst_counts", {txn_count, timeout_count}, 0);
    chk("post_rst_ready", bus.cmd_ready, 1);
    ack_force = 1'b1;
    repeat (2) @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    chk("stray_idle_txn", txn_count, 0);
    chk("stray_idle_state", {busy, bus.rsp_valid, bus.wbm_cyc_o}, 0);

    do_txn(0, 32'h3000_0004, 32'h0, 4'hF, 0, 1, 0);
    for (int i = 0; i < 258; i++)
      do_txn(0, 32'h3000_0000, 32'h0, 4'hF, NEVER, 0, 0);
    chk("timeout_sat", timeout_count, 8'hFF);
    chk("rsp_total", n_rsp, m_rsp);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone classic single-transfer initiator: the master end of the bus our Wishbone register slaves (e.g. the Fibonacci control block at 0x3000_0000) respond on.
- Accepts read/write commands over a valid/ready port, runs one bus cycle per command and returns the read data or write status word over a valid/ready response port.
- Guards against a non-responding slave with a timeout.
- Used for on-chip bring-up sequencing and as the bench driver for slave blocks.

Parameters:
- TIMEOUT_CYCLES, 15: bus-cycle count with stb high and no ack before the transfer is abandoned; legal range 1..255.
- TIMEOUT_DATA, 32'hDEADDEAD: value returned on rsp_dat for a timed-out transfer.

Ports:
- wb_clk_i  in  1  bus clock; all logic on the rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid is also high at a rising edge.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- cmd_sel  in  4  byte selects.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid is also high at a rising edge.
- rsp_dat  out  32  captured wbm_dat_i, or TIMEOUT_DATA on timeout.
- rsp_timeout  out  1  response is a timeout.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave data.
- busy  out  1  high in BUS or RESP.
- txn_count  out  16  completed transfers, including timeouts.
- timeout_count  out  8  timed-out transfers.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - State is IDLE.
  - cyc, stb, we and rsp_valid are 0. sel, adr, wbm_dat_o, rsp_dat and both counters are 0. rsp_timeout is 0.
  - cmd_ready is 0 while reset is asserted and 1 from the first edge after release.
- All outputs are registered. The exception is cmd_ready, which is decoded as (state == IDLE) and not reset.
- IDLE:
  - cmd_ready = 1.
  - On accept, latch we/adr/dat/sel onto the wbm_* outputs, set cyc = stb = 1, clear the timeout counter and go to BUS.
  - cyc/stb are therefore high from the cycle after the accept edge.
- BUS:
  - cyc, stb and all wbm_* outputs are held stable.
  - At each edge without ack, the timeout counter increments.
  - On an edge with wbm_ack_i = 1:
    - rsp_dat <= wbm_dat_i for both reads and writes, since slaves return their ACK/NACK word on writes.
    - rsp_timeout <= 0, rsp_valid <= 1, cyc = stb = 0.
    - txn_count increments; go to RESP.
  - On an edge where the counter equals TIMEOUT_CYCLES-1 and ack = 0:
    - rsp_dat <= TIMEOUT_DATA, rsp_timeout <= 1, rsp_valid <= 1, cyc = stb = 0.
    - txn_count and timeout_count increment; go to RESP.
  - If ack and timeout expiry fall on the same edge, ack wins: normal completion, no timeout.
- RESP:
  - rsp_valid, rsp_dat and rsp_timeout are held until rsp_ready = 1 at an edge.
  - On that edge: rsp_valid <= 0, go to IDLE.
  - No new command is accepted in RESP, so there is at least one idle bus cycle between transfers.
- Stray ack: wbm_ack_i outside BUS is ignored, with no state or counter change. Registered-ack slaves may pulse ack once more on the cycle after cyc/stb drop; this must not corrupt anything.
- Latency with a registered-ack slave:
  - accept edge N;
  - cyc/stb high from N;
  - slave ack sampled at N+2;
  - rsp_valid visible after N+2.
  - Minimum command-to-command time is 4 cycles with rsp_ready tied high.
- Counters: txn_count wraps 0xFFFF -> 0x0000. timeout_count saturates at 0xFF.
- busy = (state != IDLE).
- wbm_dat_o is driven on reads too (latched cmd_dat); slaves ignore it.

Test Plan:
- Read, with the Fibonacci slave at BASE 0x30000000: cmd read adr 0x30000004 sel 0xF -> one cyc/stb pulse; rsp_dat = 0x4669626F, rsp_timeout = 0, txn_count = 1; no second response from the trailing stray ack.
- Write: cmd write adr 0x3000000C dat 0x0 sel 0xF -> wbm_we_o = 1 during BUS; rsp_dat = 0x00000001; a follow-up read of 0x3000000C returns 0x00000000.
- Timeout: wbm_ack_i tied 0 -> stb high for exactly 15 cycles, then cyc/stb drop; rsp_dat = 0xDEADDEAD, rsp_timeout = 1, timeout_count = 1; the next command is accepted normally.
- Backpressure: rsp_ready held 0 for 5 cycles after completion -> rsp_valid/rsp_dat stable, cmd_ready = 0 despite cmd_valid = 1; the command is accepted the cycle after rsp_ready rises.
- Reset mid-BUS: assert wb_rst_i between edges while stb is high -> cyc/stb/rsp_valid go 0 without waiting for a clock edge; after release, IDLE with counters 0. A stray ack in IDLE does not change txn_count.
- Ack at timeout: slave acks on exactly the 15th wait edge -> normal response with captured data, rsp_timeout = 0, timeout_count unchanged.
